stepper_sequencer: RTL and testbench



---
 rtl/stepper_sequencer.sv | 155 +++++++++++++++
 tb/tb_stepper_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_sequencer.sv
// Single-axis stepper coil sequencer: accepts move commands over valid/ready, drives the
// 4-phase coil pattern at the commanded rate and tracks absolute position in half-steps.
module stepper_sequencer #(
    parameter int unsigned STEP_W = 16,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned POS_W  = 16
) (
    input  logic              system1000,
    input  logic              system1000_rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [1:0]        cmd_mode,
    input  logic [DIV_W-1:0]  cmd_period,
    input  logic              hold_en,
    input  logic              abort,
    output logic [3:0]        coils,
    output logic              busy,
    output logic              done,
    output logic [POS_W-1:0]  position
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e              state_q, state_d;
    logic [2:0]          phase_q, phase_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [3:0]          coils_q, coils_d;
    logic                done_q, done_d;
    logic                dir_q, dir_d;
    logic [1:0]          mode_q, mode_d;
    logic [DIV_W-1:0]    period_q, period_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [STEP_W-1:0]   remaining_q, remaining_d;

    logic                accept;
    logic [1:0]          step_mag;
    logic [DIV_W-1:0]    period_eff;
    logic [2:0]          phase_next;
    logic [POS_W-1:0]    pos_next;

    function automatic logic [3:0] coil_pattern(input logic [2:0] idx);
        logic [3:0] pat;
        case (idx)
            3'd0:    pat = 4'b1000;
            3'd1:    pat = 4'b1100;
            3'd2:    pat = 4'b0100;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0010;
            3'd5:    pat = 4'b0011;
            3'd6:    pat = 4'b0001;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

    assign cmd_ready = (state_q == StIdle) && !abort;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_q == StRun);
    assign done      = done_q;
    assign coils     = coils_q;
    assign position  = pos_q;

    // Wave lands on even indices, full on odd ones; mode 11 behaves as full.
    always_comb begin
        step_mag = 2'd1;
        case (mode_q)
            2'b10:   step_mag = 2'd1;
            2'b00:   step_mag = phase_q[0] ? 2'd1 : 2'd2;
            default: step_mag = phase_q[0] ? 2'd2 : 2'd1;
        endcase
    end

    assign phase_next = dir_q ? (phase_q + 3'(step_mag)) : (phase_q - 3'(step_mag));
    assign pos_next   = dir_q ? (pos_q + POS_W'(step_mag)) : (pos_q - POS_W'(step_mag));
    assign period_eff = (cmd_period == '0) ? DIV_W'(1) : cmd_period;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        pos_d       = pos_q;
        done_d      = 1'b0;
        dir_d       = dir_q;
        mode_d      = mode_q;
        period_d    = period_q;
        div_d       = div_q;
        remaining_d = remaining_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    dir_d       = cmd_dir;
                    mode_d      = cmd_mode;
                    period_d    = period_eff;
                    div_d       = period_eff - DIV_W'(1);
                    remaining_d = cmd_steps;
                    if (cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                // Abort takes priority over a coinciding divider expiry.
                if (abort) begin
                    state_d     = StIdle;
                    remaining_d = '0;
                end else if (div_q == '0) begin
                    phase_d     = phase_next;
                    pos_d       = pos_next;
                    remaining_d = remaining_q - STEP_W'(1);
                    div_d       = period_q - DIV_W'(1);
                    if (remaining_q == STEP_W'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        coils_d = ((state_d == StRun) || hold_en) ? coil_pattern(phase_d) : 4'b0000;
    end

    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            pos_q       <= '0;
            coils_q     <= '0;
            done_q      <= 1'b0;
            dir_q       <= 1'b0;
            mode_q      <= '0;
            period_q    <= '0;
            div_q       <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pos_q       <= pos_d;
            coils_q     <= coils_d;
            done_q      <= done_d;
            dir_q       <= dir_d;
            mode_q      <= mode_d;
            period_q    <= period_d;
            div_q       <= div_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_stepper_sequencer.sv
// Directed bench for stepper_sequencer: per-cycle vectors of inputs and expected outputs,
// applied to a 16-bit-position instance and a 4-bit-position instance in parallel.
module tb_stepper_sequencer;

    typedef struct {
        logic        rstn;
        logic        valid;
        logic        dir;
        logic [15:0] steps;
        logic [1:0]  mode;
        logic [15:0] period;
        logic        hold;
        logic        abrt;
        logic        rdy;
        logic [3:0]  cl;
        logic        bsy;
        logic        dn;
        logic [15:0] pos;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_dir;
    logic [15:0] cmd_steps;
    logic [1:0]  cmd_mode;
    logic [15:0] cmd_period;
    logic        hold_en;
    logic        abort;

    logic        ready_a, busy_a, done_a;
    logic [3:0]  coils_a;
    logic [15:0] pos_a;
    logic        ready_b, busy_b, done_b;
    logic [3:0]  coils_b;
    logic [3:0]  pos_b;

    int n_vec  = 0;
    int n_fail = 0;

    logic [3:0] ptab [8];
    vec_t       tbl [$];

    always #5 clk = ~clk;

    stepper_sequencer #(.STEP_W(16), .DIV_W(16), .POS_W(16)) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (ready_a),
        .cmd_dir         (cmd_dir),
        .cmd_steps       (cmd_steps),
        .cmd_mode        (cmd_mode),
        .cmd_period      (cmd_period),
        .hold_en         (hold_en),
        .abort           (abort),
        .coils           (coils_a),
        .busy            (busy_a),
        .done            (done_a),
        .position        (pos_a)
    );

    stepper_sequencer #(.STEP_W(16), .DIV_W(16), .POS_W(4)) dut4 (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (ready_b),
        .cmd_dir         (cmd_dir),
        .cmd_steps       (cmd_steps),
        .cmd_mode        (cmd_mode),
        .cmd_period      (cmd_period),
        .hold_en         (hold_en),
        .abort           (abort),
        .coils           (coils_b),
        .busy            (busy_b),
        .done            (done_b),
        .position        (pos_b)
    );

    function automatic vec_t mk(input logic rs, input logic vl, input logic dr, input int st,
                                input logic [1:0] md, input int pe, input logic hd,
                                input logic ab, input logic rd, input logic [3:0] cl,
                                input logic bs, input logic dn, input int ps);
        vec_t v;
        v.rstn   = rs;
        v.valid  = vl;
        v.dir    = dr;
        v.steps  = st[15:0];
        v.mode   = md;
        v.period = pe[15:0];
        v.hold   = hd;
        v.abrt   = ab;
        v.rdy    = rd;
        v.cl     = cl;
        v.bsy    = bs;
        v.dn     = dn;
        v.pos    = ps[15:0];
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rstn       = v.rstn;
        cmd_valid  = v.valid;
        cmd_dir    = v.dir;
        cmd_steps  = v.steps;
        cmd_mode   = v.mode;
        cmd_period = v.period;
        hold_en    = v.hold;
        abort      = v.abrt;
        #1;
        check({tag, " ready"}, {15'b0, ready_a}, {15'b0, v.rdy});
        check({tag, " coils"}, {12'b0, coils_a}, {12'b0, v.cl});
        check({tag, " busy"}, {15'b0, busy_a}, {15'b0, v.bsy});
        check({tag, " done"}, {15'b0, done_a}, {15'b0, v.dn});
        check({tag, " pos"}, pos_a, v.pos);
        check({tag, " ready4"}, {15'b0, ready_b}, {15'b0, v.rdy});
        check({tag, " coils4"}, {12'b0, coils_b}, {12'b0, v.cl});
        check({tag, " busy4"}, {15'b0, busy_b}, {15'b0, v.bsy});
        check({tag, " done4"}, {15'b0, done_b}, {15'b0, v.dn});
        check({tag, " pos4"}, {12'b0, pos_b}, {12'b0, v.pos[3:0]});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        ptab[0] = 4'b1000; ptab[1] = 4'b1100; ptab[2] = 4'b0100; ptab[3] = 4'b0110;
        ptab[4] = 4'b0010; ptab[5] = 4'b0011; ptab[6] = 4'b0001; ptab[7] = 4'b1001;

        rstn = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0;
        cmd_mode = '0; cmd_period = '0; hold_en = 1'b0; abort = 1'b0;

        // Half fwd 4 steps period 3, then reset, full rev 3 steps period 1,
        // zero-step command, abort blocking acceptance, hold_en release.
        tbl.push_back(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 4, 2'b10, 3, 1, 0, 1, 4'b1000, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 9, 2'b00, 1, 1, 0, 0, 4'b1000, 1, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 9, 2'b00, 1, 1, 0, 0, 4'b1100, 1, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 9, 2'b00, 1, 1, 0, 0, 4'b0100, 1, 0, 2));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 9, 2'b00, 1, 1, 0, 0, 4'b0110, 1, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 1, 4'b0010, 0, 1, 4));
        tbl.push_back(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 1, 4'b0010, 0, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 1, 4'b0010, 0, 0, 4));
        tbl.push_back(mk(1, 1, 0, 3, 2'b01, 1, 1, 0, 1, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 7, 2'b10, 4, 1, 0, 0, 4'b1000, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 7, 2'b10, 4, 1, 0, 0, 4'b1001, 1, 0, -1));
        tbl.push_back(mk(1, 0, 1, 7, 2'b10, 4, 1, 0, 0, 4'b0011, 1, 0, -3));
        tbl.push_back(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 1, 4'b0110, 0, 1, -5));
        tbl.push_back(mk(1, 1, 1, 0, 2'b10, 5, 1, 0, 1, 4'b0110, 0, 0, -5));
        tbl.push_back(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 1, 4'b0110, 0, 1, -5));
        tbl.push_back(mk(1, 1, 1, 3, 2'b10, 1, 1, 1, 0, 4'b0110, 0, 0, -5));
        tbl.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 4'b0110, 0, 0, -5));
        tbl.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 4'b0000, 0, 0, -5));

        do_reset();
        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

        // Reset in the middle of a half-step move.
        do_reset();
        apply(mk(1, 1, 1, 10, 2'b10, 1, 0, 0, 1, 4'b0000, 0, 0, 0), "rst_accept");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b1000, 1, 0, 0), "rst_run0");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b1100, 1, 0, 1), "rst_run1");
        apply(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b0100, 1, 0, 2), "rst_low0");
        apply(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 4'b0000, 0, 0, 0), "rst_low1");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 4'b0000, 0, 0, 0), "rst_rel0");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 4'b0000, 0, 0, 0), "rst_rel1");

        // Abort after the second step, hold_en=0: coils drop, no done.
        do_reset();
        apply(mk(1, 1, 1, 10, 2'b10, 2, 0, 0, 1, 4'b0000, 0, 0, 0), "ab0_accept");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b1000, 1, 0, 0), "ab0_c1");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b1000, 1, 0, 0), "ab0_c2");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b1100, 1, 0, 1), "ab0_c3");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 4'b1100, 1, 0, 1), "ab0_c4");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 0, 1, 0, 4'b0100, 1, 0, 2), "ab0_abort");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 4'b0000, 0, 0, 2), "ab0_after0");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 1, 4'b0000, 0, 0, 2), "ab0_after1");

        // Abort coinciding with divider expiry, hold_en=1: no step, coils hold 0100.
        do_reset();
        apply(mk(1, 1, 1, 10, 2'b10, 2, 1, 0, 1, 4'b0000, 0, 0, 0), "ab1_accept");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 0, 4'b1000, 1, 0, 0), "ab1_c1");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 0, 4'b1000, 1, 0, 0), "ab1_c2");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 0, 4'b1100, 1, 0, 1), "ab1_c3");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 0, 4'b1100, 1, 0, 1), "ab1_c4");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 0, 4'b0100, 1, 0, 2), "ab1_c5");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 1, 1, 0, 4'b0100, 1, 0, 2), "ab1_abort");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 1, 4'b0100, 0, 0, 2), "ab1_after0");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 1, 4'b0100, 0, 0, 2), "ab1_after1");

        // Period 0 runs at one step per clock; 4-bit position wraps 17 -> 1.
        do_reset();
        apply(mk(1, 1, 1, 17, 2'b10, 0, 1, 0, 1, 4'b0000, 0, 0, 0), "wr_accept");
        for (int j = 1; j <= 17; j++)
            apply(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 0, ptab[(j - 1) % 8], 1, 0, j - 1),
                  $sformatf("wr_run%0d", j));
        // Back-to-back wave command offered in the done cycle.
        apply(mk(1, 1, 1, 1, 2'b00, 1, 1, 0, 1, 4'b1100, 0, 1, 17), "b2b_accept");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 0, 4'b1100, 1, 0, 17), "b2b_run");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 1, 4'b0100, 0, 1, 18), "b2b_done");
        // Wave from an even index moves by 2.
        apply(mk(1, 1, 1, 2, 2'b00, 1, 1, 0, 1, 4'b0100, 0, 0, 18), "wv_accept");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 0, 4'b0100, 1, 0, 18), "wv_run0");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 0, 4'b0010, 1, 0, 20), "wv_run1");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 1, 4'b0001, 0, 1, 22), "wv_done");
        apply(mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 1, 4'b0001, 0, 0, 22), "wv_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
